// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the MEM-stage access sequencer.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         TIMEOUT_DEF     = 15;
endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter; done flags that TIMEOUT cycles have elapsed since clear.
import mips_pkg::*;
module mem_wait_timer #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign done = (cnt == W'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (enable && !done)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one req/ack data-memory access per instruction, stalling
// the pipeline until the access completes, is rejected, or times out.
import mips_pkg::*;
module mem_access_ctrl #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [31:0] i_ALUresult,
  input  logic [31:0] i_writedata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_err
);
  mem_state_t state, state_n;
  logic access, illegal, tmr_clr, tmr_en, tmr_done;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .done   (tmr_done)
  );

  always_comb begin
    access  = i_MemRead | i_MemWrite;
    illegal = (i_MemRead & i_MemWrite) | ((i_ALUresult[1:0] & WORD_ALIGN_MASK) != 2'b00);
    state_n = state;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state)
      IDLE: if (access) begin
        state_n = illegal ? DONE : WAIT;
        tmr_clr = !illegal;
      end
      // ack is checked first so a same-cycle ack beats the timeout
      WAIT: if (i_mem_ack || tmr_done) state_n = DONE;
            else                        tmr_en  = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  assign o_stall = i_rst_n & (((state == IDLE) & access) | (state == WAIT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Pulses are produced on the edge entering DONE so they are visible exactly in DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_rdata_valid <= 1'b0;
      o_err         <= 1'b0;
      case (state)
        IDLE: if (access) begin
          if (illegal) begin
            o_err <= 1'b1;
          end else begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_MemWrite;
            o_mem_addr  <= i_ALUresult;
            o_mem_wdata <= i_writedata;
          end
        end
        WAIT: if (i_mem_ack) begin
          o_mem_req <= 1'b0;
          if (!o_mem_we) begin
            o_rdata       <= i_mem_rdata;
            o_rdata_valid <= 1'b1;
          end
        end else if (tmr_done) begin
          o_mem_req <= 1'b0;
          o_rdata   <= '0;
          o_err     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the pipelined MIPS core. Takes the memory-control and data outputs of the EX/MEM pipeline register and drives a variable-latency data-memory port with a req/ack handshake. Asserts a pipeline stall while an access is outstanding and returns load data to the MEM/WB path. Also screens each access for misalignment, read/write conflict and memory timeout.

## Interface
- TIMEOUT, 15: maximum cycles spent waiting for `i_mem_ack` before aborting (≥1).
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_MemRead  in  1  load request from EX/MEM
- i_MemWrite  in  1  store request from EX/MEM
- i_ALUresult  in  32  byte address from EX/MEM
- i_writedata  in  32  store data from EX/MEM
- o_mem_req  out  1  memory request, held until ack or abort
- o_mem_we  out  1  1 = write, valid with req
- o_mem_addr  out  32  latched address
- o_mem_wdata  out  32  latched store data
- i_mem_ack  in  1  memory completion, sampled only while req is high
- i_mem_rdata  in  32  read data, valid with ack
- o_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB
- o_rdata  out  32  load result
- o_rdata_valid  out  1  one-cycle pulse, load completed
- o_err  out  1  one-cycle pulse, access aborted

## Operation
- States: IDLE, WAIT, DONE.
- IDLE, with `access = i_MemRead | i_MemWrite` equal to 0: no activity, stay in IDLE.
- IDLE, with access equal to 1: check for an illegal request.
  - Illegal means both read and write are high, or `i_ALUresult[1:0] != 0`.
  - Illegal request: go to DONE with the err flag set, no request issued.
  - Legal request: latch addr, wdata and we (`we = i_MemWrite`), set `o_mem_req`, clear the timer, go to WAIT.
- WAIT, `i_mem_ack` = 1: drop req.
  - If the access is a read, capture `i_mem_rdata` into `o_rdata`.
  - Go to DONE.
- WAIT, no ack, timer reaches TIMEOUT: drop req, set `o_rdata` = 0, set the err flag, go to DONE.
- WAIT, no ack, timer below TIMEOUT: increment the timer.
- DONE: `o_rdata_valid` = read & !err; `o_err` = err. Always go to IDLE next.
  - DONE lasts exactly one cycle.
  - The EX/MEM register releases at the end of DONE, so the same instruction is never reissued.
- `o_stall = i_rst_n & ((IDLE & access) | WAIT)`. This is the only combinational output; all others are registered.
- Stores never pulse `o_rdata_valid`. `o_rdata` holds its last value outside DONE.

## Timing
- Reset (asynchronous, takes effect immediately mid-operation): state = IDLE, timer = 0, and all registered outputs are 0.
  - Registered outputs: `o_mem_req`, `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_rdata`, `o_rdata_valid`, `o_err`.
  - `o_stall` is 0 while `i_rst_n` = 0.
  - An outstanding request is dropped without waiting for ack.
  - An ack arriving after reset is ignored.
- Legal access presented in cycle T:
  - Cycle T: stall.
  - Cycle T+1: req high.
  - Earliest ack sampled at the end of T+1.
  - DONE in T+2.
- Minimum total: 2 stall cycles and 3 cycles per access. Every extra cycle without ack adds one stall cycle.
- Timeout: DONE occurs TIMEOUT+1 cycles after req rises.
- Illegal access: stall in T only; DONE with `o_err` in T+1.
- Back-to-back accesses: the next access is evaluated in the IDLE cycle after DONE. There is no overlap.
- Ack in the same cycle the timer reaches TIMEOUT: ack wins, no error.

## Structure
- Shared package `mips_pkg`:
  - `mem_state_t` enum (IDLE/WAIT/DONE)
  - `WORD_ALIGN_MASK = 2'b11`
  - default `TIMEOUT` constant
- Sub-module `mem_wait_timer`:
  - Ports: clear, enable, `done` at TIMEOUT.
  - Counter width is `$clog2(TIMEOUT+1)`, saturating.

## Test plan
- Load: addr 0x0000_0010, ack on the first WAIT cycle with rdata 0xDEAD_BEEF.
  - Required: stall exactly 2 cycles.
  - Required: `o_rdata_valid` pulse with 0xDEAD_BEEF in T+2.
- Store: addr 0x0000_0020, data 0x1234_5678, ack after 3 WAIT cycles.
  - Required: `o_mem_we` = 1 with latched addr/data stable throughout.
  - Required: stall 4 cycles.
  - Required: no `o_rdata_valid`.
- Load with no ack, TIMEOUT = 15.
  - Required: req held 16 cycles, then dropped.
  - Required: `o_err` pulse, `o_rdata` = 0, stall released after DONE.
- Misaligned load at 0x0000_0013, then MemRead = MemWrite = 1 at 0x0000_0040.
  - Required for each: no req, 1 stall cycle, `o_err` pulse.
- Two consecutive loads, each acked immediately.
  - Required: second req rises exactly 3 cycles after the first.
  - Required: two distinct valid pulses.
- Reset asserted during WAIT, then ack arrives.
  - Required: req and stall drop the same cycle.
  - Required: state is IDLE and the late ack causes no valid pulse.
